// File: rtl/compressor_pkg.sv
// Shared constants for the lane pattern compressor.
//   TAG_W       : width of one per-lane tag
//   TAG_ZERO    : lane word is all zeros
//   TAG_REPEAT  : lane word equals the previous word
//   TAG_LITERAL : lane word is emitted in the packed literal stream
//   TAG_RAW     : beat was passed through uncompressed (bypass)
package compressor_pkg;
  localparam int TAG_W = 2;
  localparam logic [TAG_W-1:0] TAG_ZERO    = 2'b00;
  localparam logic [TAG_W-1:0] TAG_REPEAT  = 2'b01;
  localparam logic [TAG_W-1:0] TAG_LITERAL = 2'b10;
  localparam logic [TAG_W-1:0] TAG_RAW     = 2'b11;
endpackage

// File: rtl/cmp_in_fifo.sv
// Input FIFO for the lane pattern compressor.
//   clk, reset : clock, asynchronous active-high reset (pointers and overflow)
//   push       : write wr_data; dropped when full unless a pop frees a slot this cycle
//   wr_data    : entry to store
//   pop        : remove the head entry (ignored when empty)
//   rd_data    : head entry (meaningful only when !empty)
//   full/empty : occupancy status
//   overflow   : sticky, set when a push is dropped
module cmp_in_fifo #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra top bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/lane_pattern_compressor.sv
// Lane pattern compressor: classifies each lane of a beat as ZERO, REPEAT or
// LITERAL and packs the literal words toward lane 0. Bypass beats pass through
// tagged RAW.
//   clk, reset  : clock, asynchronous active-high reset
//   push_infifo : write {bypass, data_in} into the input FIFO
//   data_in     : LANES words, lane i = data_in[i*LANE_W +: LANE_W]
//   bypass      : pass this beat through uncompressed
//   full        : input FIFO full
//   overflow    : sticky, a push was dropped
//   out_valid   : data_out/tag_out/lit_cnt valid
//   out_ready   : downstream accepts the current output
//   data_out    : packed literals, lane 0 first, unused lanes zero
//   tag_out     : lane i tag = tag_out[2i+1:2i]
//   lit_cnt     : number of meaningful lanes in data_out
module lane_pattern_compressor
  import compressor_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int LANE_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_infifo,
  input  logic [LANES*LANE_W-1:0]      data_in,
  input  logic                         bypass,
  output logic                         full,
  output logic                         overflow,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*LANE_W-1:0]      data_out,
  output logic [TAG_W*LANES-1:0]       tag_out,
  output logic [$clog2(LANES+1)-1:0]   lit_cnt
);
  localparam int BEAT_W = LANES * LANE_W;
  localparam int CNT_W  = $clog2(LANES + 1);

  logic [BEAT_W:0]        fifo_rd;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [BEAT_W-1:0]      beat_in;
  logic                   byp_in;
  logic [BEAT_W-1:0]      prev_words;
  logic [TAG_W*LANES-1:0] tag_c;

  logic                   s1_adv;
  logic                   s2_adv;

  logic                   vld_p1;
  logic                   byp_p1;
  logic [BEAT_W-1:0]      data_p1;
  logic [TAG_W*LANES-1:0] tag_p1;
  logic [LANE_W-1:0]      hist_p1;

  logic [BEAT_W-1:0]      comp_data;
  logic [CNT_W-1:0]       comp_cnt;
  int                     pos;

  logic                   vld_p2;
  logic [BEAT_W-1:0]      data_p2;
  logic [TAG_W*LANES-1:0] tag_p2;
  logic [CNT_W-1:0]       cnt_p2;

  function automatic logic [TAG_W-1:0] classify(input logic [LANE_W-1:0] word,
                                                input logic [LANE_W-1:0] prev);
    if (word == '0)   return TAG_ZERO;
    if (word == prev) return TAG_REPEAT;
    return TAG_LITERAL;
  endfunction

  cmp_in_fifo #(
    .WIDTH (BEAT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_infifo),
    .wr_data  ({bypass, data_in}),
    .pop      (fifo_pop),
    .rd_data  (fifo_rd),
    .full     (full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  // Backpressure chain: each stage loads only when the one after it has room.
  assign s2_adv   = !vld_p2 || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign fifo_pop = s1_adv && !fifo_empty;

  assign beat_in = fifo_rd[BEAT_W-1:0];
  assign byp_in  = fifo_rd[BEAT_W];
  // Lane i of prev_words is the word lane i is compared against.
  assign prev_words = {beat_in[BEAT_W-LANE_W-1:0], hist_p1};

  always_comb begin
    tag_c = '0;
    for (int i = 0; i < LANES; i++) begin
      tag_c[TAG_W*i +: TAG_W] = byp_in ? TAG_RAW
                                       : classify(beat_in[i*LANE_W +: LANE_W],
                                                  prev_words[i*LANE_W +: LANE_W]);
    end
  end

  // ---- Stage 1: classification registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      hist_p1 <= '0;
    end else begin
      if (s1_adv)   vld_p1  <= !fifo_empty;
      if (fifo_pop) hist_p1 <= beat_in[BEAT_W-1 -: LANE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      data_p1 <= beat_in;
      tag_p1  <= tag_c;
      byp_p1  <= byp_in;
    end
  end

  // Prefix-sum compaction: each literal lands at the count of literals below it.
  always_comb begin
    comp_data = '0;
    pos       = 0;
    for (int i = 0; i < LANES; i++) begin
      if (tag_p1[TAG_W*i +: TAG_W] == TAG_LITERAL) begin
        comp_data[pos*LANE_W +: LANE_W] = data_p1[i*LANE_W +: LANE_W];
        pos = pos + 1;
      end
    end
    comp_cnt = CNT_W'(pos);
  end

  // ---- Stage 2: compaction / output registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      tag_p2  <= '0;
      cnt_p2  <= '0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= byp_p1 ? data_p1 : comp_data;
        tag_p2  <= tag_p1;
        cnt_p2  <= byp_p1 ? CNT_W'(LANES) : comp_cnt;
      end
    end
  end

  assign out_valid = vld_p2;
  assign data_out  = data_p2;
  assign tag_out   = tag_p2;
  assign lit_cnt   = cnt_p2;
endmodule
